// File: rtl/microsequencer_pkg.sv
// ============================================================================
// microsequencer_pkg : shared state encodings, branch codes and widths
// Rev 1.0
// ============================================================================
`default_nettype none

package microsequencer_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 35;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } useq_state_t;

  localparam logic [1:0] BR_SEQ  = 2'b00;
  localparam logic [1:0] BR_BZ   = 2'b01;
  localparam logic [1:0] BR_BNZ  = 2'b10;
  localparam logic [1:0] BR_DISP = 2'b11;

endpackage

`default_nettype wire

// File: rtl/microsequencer_if.sv
// ============================================================================
// microsequencer_if : control-store, controlSignals and status bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface microsequencer_if
  import microsequencer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          start;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] romin;
  logic          romin_vld;
  logic [AW-1:0] nxtadd;
  logic [1:0]    br_type;
  logic          z_flag;
  logic [3:0]    opcode;
  logic          stall;
  logic [AW-1:0] upc;
  logic          halted;

  modport master (
    input  start, rom_data, nxtadd, br_type, z_flag, opcode, stall,
    output rom_addr, romin, romin_vld, upc, halted
  );

  modport slave (
    output start, rom_data, nxtadd, br_type, z_flag, opcode, stall,
    input  rom_addr, romin, romin_vld, upc, halted
  );

endinterface

`default_nettype wire

// File: rtl/microsequencer_next_addr.sv
// ============================================================================
// useq_next_addr : combinational next micro-PC selection by branch type
// Rev 1.0
// ============================================================================
`default_nettype none

module useq_next_addr
  import microsequencer_pkg::*;
#(
  parameter int            AW        = AW_DEF,
  parameter logic [AW-1:0] DISP_BASE = AW'(16)
) (
  input  wire logic [1:0]    i_br_type,
  input  wire logic          i_z_flag,
  input  wire logic [AW-1:0] i_nxtadd,
  input  wire logic [AW-1:0] i_upc,
  input  wire logic [3:0]    i_opcode,
  output logic      [AW-1:0] o_next
);

  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_disp;

  // Both sums wrap modulo 2**AW by construction of the AW-bit result.
  assign w_inc  = i_upc + AW'(1);
  assign w_disp = DISP_BASE + AW'({1'b0, i_opcode});

  always_comb begin
    o_next = i_nxtadd;
    case (i_br_type)
      BR_SEQ:  o_next = i_nxtadd;
      BR_BZ:   o_next = i_z_flag ? i_nxtadd : w_inc;
      BR_BNZ:  o_next = i_z_flag ? w_inc : i_nxtadd;
      BR_DISP: o_next = w_disp;
      default: o_next = i_nxtadd;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/microsequencer.sv
// ============================================================================
// microsequencer : micro-PC, control-store fetch and FETCH/EXEC sequencing
// Rev 1.0
// ============================================================================
`default_nettype none

module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int            AW         = AW_DEF,
  parameter int            DW         = DW_DEF,
  parameter logic [AW-1:0] RESET_ADDR = AW'(0),
  parameter logic [AW-1:0] HALT_ADDR  = AW'(31),
  parameter logic [AW-1:0] DISP_BASE  = AW'(16)
) (
  input  wire logic         clk,
  input  wire logic         reset,
  microsequencer_if.master  bus
);

  useq_state_t   r_state;
  useq_state_t   w_state_nxt;
  logic [AW-1:0] r_upc;
  logic [AW-1:0] w_upc_nxt;
  logic [DW-1:0] r_romin;
  logic [DW-1:0] w_romin_nxt;
  logic [AW-1:0] w_next;
  logic          w_halt_req;

  useq_next_addr #(
    .AW        (AW),
    .DISP_BASE (DISP_BASE)
  ) u_next_addr (
    .i_br_type (bus.br_type),
    .i_z_flag  (bus.z_flag),
    .i_nxtadd  (bus.nxtadd),
    .i_upc     (r_upc),
    .i_opcode  (bus.opcode),
    .o_next    (w_next)
  );

  assign w_halt_req = (bus.nxtadd == HALT_ADDR) && (bus.br_type == BR_SEQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_upc   <= RESET_ADDR;
      r_romin <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_upc   <= w_upc_nxt;
      r_romin <= w_romin_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_upc_nxt   = r_upc;
    w_romin_nxt = r_romin;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_romin_nxt = bus.rom_data;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        // A stalled EXEC freezes everything, including a pending halt.
        if (!bus.stall) begin
          if (w_halt_req) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_upc_nxt   = w_next;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        if (bus.start) begin
          w_upc_nxt   = RESET_ADDR;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.rom_addr  = r_upc;
  assign bus.upc       = r_upc;
  assign bus.romin     = r_romin;
  assign bus.romin_vld = (r_state == ST_EXEC);
  assign bus.halted    = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_microsequencer.sv
// ============================================================================
// tb_microsequencer : directed self-checking bench for microsequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_microsequencer;
  import microsequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [34:0] rom [32];

  microsequencer_if #(.AW(5), .DW(35)) bus ();

  microsequencer #(
    .AW         (5),
    .DW         (35),
    .RESET_ADDR (5'd0),
    .HALT_ADDR  (5'd31),
    .DISP_BASE  (5'd16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entry: DUT in EXEC. Executes one microinstruction, checks the new upc
  // in FETCH, then checks the refetched word in EXEC.
  task automatic exec_step(input logic [1:0] br, input logic [4:0] nx, input logic z,
                           input logic [3:0] op, input logic [4:0] exp_upc, input string tag);
    bus.br_type = br;
    bus.nxtadd  = nx;
    bus.z_flag  = z;
    bus.opcode  = op;
    tick();
    chk({tag, "_upc"}, 64'(bus.upc), 64'(exp_upc));
    chk({tag, "_addr"}, 64'(bus.rom_addr), 64'(exp_upc));
    chk({tag, "_vld0"}, 64'(bus.romin_vld), 64'd0);
    tick();
    chk({tag, "_vld1"}, 64'(bus.romin_vld), 64'd1);
    chk({tag, "_romin"}, 64'(bus.romin), 64'(rom[exp_upc]));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) rom[i] = {3'(i), 32'hC0DE_0000 | 32'(i)};
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.nxtadd  = 5'd0;
    bus.br_type = BR_SEQ;
    bus.z_flag  = 1'b0;
    bus.opcode  = 4'd0;
    bus.stall   = 1'b0;

    #3;
    chk("rst_upc", 64'(bus.upc), 64'd0);
    chk("rst_romin", 64'(bus.romin), 64'd0);
    chk("rst_vld", 64'(bus.romin_vld), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    #9 rst_n = 1'b1;

    tick();
    tick();
    chk("idle_vld", 64'(bus.romin_vld), 64'd0);
    chk("idle_upc", 64'(bus.upc), 64'd0);

    // start -> FETCH at edge 0, EXEC with valid romin after edge 1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("fetch0_vld", 64'(bus.romin_vld), 64'd0);
    chk("fetch0_addr", 64'(bus.rom_addr), 64'd0);
    tick();
    chk("exec0_vld", 64'(bus.romin_vld), 64'd1);
    chk("exec0_romin", 64'(bus.romin), 64'(rom[0]));

    exec_step(BR_SEQ,  5'd5, 1'b0, 4'h0, 5'd5,  "seq5");
    exec_step(BR_SEQ,  5'd3, 1'b0, 4'h0, 5'd3,  "to3a");
    exec_step(BR_BZ,   5'd9, 1'b1, 4'h0, 5'd9,  "bz_z1");
    exec_step(BR_SEQ,  5'd3, 1'b0, 4'h0, 5'd3,  "to3b");
    exec_step(BR_BZ,   5'd9, 1'b0, 4'h0, 5'd4,  "bz_z0");
    exec_step(BR_SEQ,  5'd3, 1'b0, 4'h0, 5'd3,  "to3c");
    exec_step(BR_BNZ,  5'd9, 1'b1, 4'h0, 5'd4,  "bnz_z1");
    exec_step(BR_SEQ,  5'd3, 1'b0, 4'h0, 5'd3,  "to3d");
    exec_step(BR_BNZ,  5'd9, 1'b0, 4'h0, 5'd9,  "bnz_z0");
    exec_step(BR_DISP, 5'd2, 1'b0, 4'hF, 5'd31, "disp_f");
    exec_step(BR_BZ,   5'd9, 1'b0, 4'h0, 5'd0,  "bz_wrap");
    exec_step(BR_DISP, 5'd2, 1'b1, 4'h0, 5'd16, "disp_0");
    exec_step(BR_SEQ,  5'd12, 1'b0, 4'h0, 5'd12, "seq12");

    // stall while a halt is pending: everything holds
    bus.br_type = BR_SEQ;
    bus.nxtadd  = 5'd31;
    bus.stall   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.z_flag = ~bus.z_flag;
      tick();
      chk("stall_upc", 64'(bus.upc), 64'd12);
      chk("stall_romin", 64'(bus.romin), 64'(rom[12]));
      chk("stall_vld", 64'(bus.romin_vld), 64'd1);
      chk("stall_halted", 64'(bus.halted), 64'd0);
    end
    bus.stall = 1'b0;
    tick();
    chk("halt_halted", 64'(bus.halted), 64'd1);
    chk("halt_upc", 64'(bus.upc), 64'd12);
    chk("halt_vld", 64'(bus.romin_vld), 64'd0);
    tick();
    chk("halt_hold", 64'(bus.halted), 64'd1);

    // restart from HALT; start held high through FETCH and EXEC is ignored
    bus.start = 1'b1;
    tick();
    chk("restart_upc", 64'(bus.upc), 64'd0);
    chk("restart_halted", 64'(bus.halted), 64'd0);
    chk("restart_vld", 64'(bus.romin_vld), 64'd0);
    tick();
    chk("fetch_start_vld", 64'(bus.romin_vld), 64'd1);
    chk("fetch_start_upc", 64'(bus.upc), 64'd0);
    chk("fetch_start_romin", 64'(bus.romin), 64'(rom[0]));
    exec_step(BR_SEQ, 5'd7, 1'b0, 4'h0, 5'd7, "exec_start");
    bus.start = 1'b0;

    // asynchronous reset in EXEC at upc=7
    #2 rst_n = 1'b0;
    #1;
    chk("arst_upc", 64'(bus.upc), 64'd0);
    chk("arst_romin", 64'(bus.romin), 64'd0);
    chk("arst_vld", 64'(bus.romin_vld), 64'd0);
    chk("arst_halted", 64'(bus.halted), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_vld", 64'(bus.romin_vld), 64'd0);
    chk("post_rst_upc", 64'(bus.upc), 64'd0);
    chk("post_rst_romin", 64'(bus.romin), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
